// File: rtl/CONSTANTS.sv
// Shared board/sprite constants: screen limits, square size, piece codes, sprite ROM bases.
// Latency: n/a (package only).
// Backpressure: n/a.
package CONSTANTS;

   // Visible screen window and board geometry
   localparam int SCREEN_MIN_X = 80;
   localparam int SCREEN_MAX_X = 799;
   localparam int SCREEN_MIN_Y = 0;
   localparam int SCREEN_MAX_Y = 524;
   localparam int SQUARE_DIM   = 60;
   localparam int BOARD_DIM    = 8;

   // Sprite ROM layout: one 60x60 sprite per piece, black/white interleaved per type
   localparam logic [16:0] PAWN_BLACK_ROM   = 17'd0;
   localparam logic [16:0] PAWN_WHITE_ROM   = 17'd3600;
   localparam logic [16:0] KNIGHT_BLACK_ROM = 17'd7200;
   localparam logic [16:0] KNIGHT_WHITE_ROM = 17'd10800;
   localparam logic [16:0] BISHOP_BLACK_ROM = 17'd14400;
   localparam logic [16:0] BISHOP_WHITE_ROM = 17'd18000;
   localparam logic [16:0] ROOK_BLACK_ROM   = 17'd21600;
   localparam logic [16:0] ROOK_WHITE_ROM   = 17'd25200;
   localparam logic [16:0] QUEEN_BLACK_ROM  = 17'd28800;
   localparam logic [16:0] QUEEN_WHITE_ROM  = 17'd32400;
   localparam logic [16:0] KING_BLACK_ROM   = 17'd36000;
   localparam logic [16:0] KING_WHITE_ROM   = 17'd39600;

   // Piece codes held in the board RAM; bit 3 set = black. 0111, 1000, 1111 are unused.
   typedef enum logic [3:0] {
      EMPTY        = 4'b0000,
      PAWN_WHITE   = 4'b0001,
      KNIGHT_WHITE = 4'b0010,
      BISHOP_WHITE = 4'b0011,
      ROOK_WHITE   = 4'b0100,
      QUEEN_WHITE  = 4'b0101,
      KING_WHITE   = 4'b0110,
      PAWN_BLACK   = 4'b1001,
      KNIGHT_BLACK = 4'b1010,
      BISHOP_BLACK = 4'b1011,
      ROOK_BLACK   = 4'b1100,
      QUEEN_BLACK  = 4'b1101,
      KING_BLACK   = 4'b1110
   } piece_e;

   typedef struct packed {
      logic        legal;
      logic [16:0] base;
   } sprite_sel_t;

   // Per-pixel metadata carried down the address pipeline
   typedef struct packed {
      logic       vld;
      logic       in_b;
      logic [2:0] row;
      logic [2:0] col;
      logic [5:0] px;
      logic [5:0] py;
      logic       hl;
   } pix_meta_t;

   // Piece code -> sprite ROM base; legal=0 for EMPTY and unused codes
   function automatic sprite_sel_t piece_rom_base(input logic [3:0] code);
      sprite_sel_t sel;
      sel.legal = 1'b1;
      sel.base  = '0;
      case (code)
         PAWN_WHITE:   sel.base = PAWN_WHITE_ROM;
         KNIGHT_WHITE: sel.base = KNIGHT_WHITE_ROM;
         BISHOP_WHITE: sel.base = BISHOP_WHITE_ROM;
         ROOK_WHITE:   sel.base = ROOK_WHITE_ROM;
         QUEEN_WHITE:  sel.base = QUEEN_WHITE_ROM;
         KING_WHITE:   sel.base = KING_WHITE_ROM;
         PAWN_BLACK:   sel.base = PAWN_BLACK_ROM;
         KNIGHT_BLACK: sel.base = KNIGHT_BLACK_ROM;
         BISHOP_BLACK: sel.base = BISHOP_BLACK_ROM;
         ROOK_BLACK:   sel.base = ROOK_BLACK_ROM;
         QUEEN_BLACK:  sel.base = QUEEN_BLACK_ROM;
         KING_BLACK:   sel.base = KING_BLACK_ROM;
         default:      sel.legal = 1'b0;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/sq_locate.sv
// Square locator for one axis: square index and in-square offset via threshold compares.
// Latency: combinational.
// Backpressure: none.
// Ports: pos_i screen coordinate; in_range_o inside the 8-square span;
//        idx_o square index 0..7; ofs_o offset 0..59 within that square.
module sq_locate
   import CONSTANTS::*;
#(
   parameter int ORIGIN = 0
) (
   input  logic [9:0] pos_i,
   output logic       in_range_o,
   output logic [2:0] idx_o,
   output logic [5:0] ofs_o
);

   logic [10:0] rel;
   logic [10:0] base;

   // One extra bit so coordinates left of the origin wrap to a huge value
   // and fall out of range on the same compare as the right edge.
   assign rel = {1'b0, pos_i} - 11'(ORIGIN);

   always_comb begin
      idx_o = '0;
      base  = '0;
      for (int k = 1; k < BOARD_DIM; k++) begin
         if (rel >= 11'(k * SQUARE_DIM)) begin
            idx_o = 3'(k);
            base  = 11'(k * SQUARE_DIM);
         end
      end
      in_range_o = (rel < 11'(BOARD_DIM * SQUARE_DIM));
      ofs_o      = 6'(rel - base);
   end

endmodule

// File: rtl/board_sprite_addr.sv
// Per-pixel chess board lookup: square, colour, highlight, sprite ROM address.
// Latency: 3 cycles, one pixel per cycle.
// Backpressure: none; the pipeline never stalls.
// Ports: Clk/Reset (sync, active high); pix_valid/DrawX/DrawY pixel in;
//        sel_valid/sel_sq selected square; board_rd_addr/board_rd_data board RAM port;
//        out_valid/in_board/light_square/highlight/draw_piece/rom_addr results at T+3.
module board_sprite_addr
   import CONSTANTS::*;
#(
   parameter int X_ORIGIN = SCREEN_MIN_X,
   parameter int Y_ORIGIN = SCREEN_MIN_Y
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        pix_valid,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic        sel_valid,
   input  logic [5:0]  sel_sq,
   output logic [5:0]  board_rd_addr,
   input  logic [3:0]  board_rd_data,
   output logic        out_valid,
   output logic        in_board,
   output logic        light_square,
   output logic        highlight,
   output logic        draw_piece,
   output logic [16:0] rom_addr
);

   logic       x_in, y_in;
   logic [2:0] col_raw, row_raw;
   logic [5:0] px_raw, py_raw;

   sq_locate #(.ORIGIN(X_ORIGIN)) u_col (
      .pos_i      (DrawX),
      .in_range_o (x_in),
      .idx_o      (col_raw),
      .ofs_o      (px_raw)
   );

   sq_locate #(.ORIGIN(Y_ORIGIN)) u_row (
      .pos_i      (DrawY),
      .in_range_o (y_in),
      .idx_o      (row_raw),
      .ofs_o      (py_raw)
   );

   pix_meta_t   s1_d, s1_q, s2_q;
   logic [5:0]  rd_addr_d, rd_addr_q;
   sprite_sel_t sel;
   logic        out_valid_d, in_board_d, light_d, highlight_d, draw_d;
   logic [16:0] rom_d;
   logic        out_valid_q, in_board_q, light_q, highlight_q, draw_q;
   logic [16:0] rom_q;

   // Stage 1: locate the square; off-board pixels collapse to square 0, offset 0.
   always_comb begin
      s1_d      = '0;
      rd_addr_d = '0;
      s1_d.vld  = pix_valid;
      s1_d.in_b = x_in && y_in;
      if (x_in && y_in) begin
         s1_d.row  = row_raw;
         s1_d.col  = col_raw;
         s1_d.px   = px_raw;
         s1_d.py   = py_raw;
         rd_addr_d = {row_raw, col_raw};
      end
      s1_d.hl = sel_valid && x_in && y_in && (sel_sq == {row_raw, col_raw});
   end

   // Stage 3: the RAM's own output register is the stage-2 piece capture, so
   // board_rd_data lines up with s2_q here.
   always_comb begin
      sel         = piece_rom_base(board_rd_data);
      out_valid_d = s2_q.vld;
      in_board_d  = s2_q.in_b;
      light_d     = s2_q.in_b && !(s2_q.row[0] ^ s2_q.col[0]);
      highlight_d = s2_q.hl;
      draw_d      = s2_q.in_b && sel.legal;
      rom_d       = '0;
      if (draw_d) begin
         rom_d = sel.base + 17'(s2_q.py) * 17'(SQUARE_DIM) + 17'(s2_q.px);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         s1_q        <= '0;
         s2_q        <= '0;
         rd_addr_q   <= '0;
         out_valid_q <= 1'b0;
         in_board_q  <= 1'b0;
         light_q     <= 1'b0;
         highlight_q <= 1'b0;
         draw_q      <= 1'b0;
         rom_q       <= '0;
      end else begin
         s1_q        <= s1_d;
         s2_q        <= s1_q;
         rd_addr_q   <= rd_addr_d;
         out_valid_q <= out_valid_d;
         in_board_q  <= in_board_d;
         light_q     <= light_d;
         highlight_q <= highlight_d;
         draw_q      <= draw_d;
         rom_q       <= rom_d;
      end
   end

   assign board_rd_addr = rd_addr_q;
   assign out_valid     = out_valid_q;
   assign in_board      = in_board_q;
   assign light_square  = light_q;
   assign highlight     = highlight_q;
   assign draw_piece    = draw_q;
   assign rom_addr      = rom_q;

endmodule

// File: doc/board_sprite_addr.md
BOARD_SPRITE_ADDR -- requirements
Module: board_sprite_addr

Interface
REQ-001 Parameter X_ORIGIN, default SCREEN_MIN_X (80): left pixel column of the board area.
REQ-002 Parameter Y_ORIGIN, default SCREEN_MIN_Y (0): top pixel row of the board area.
REQ-003 Clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 pix_valid  input  1  DrawX/DrawY carry a pixel this cycle.
REQ-006 DrawX  input  10  pixel column, 0..799.
REQ-007 DrawY  input  10  pixel row, 0..524.
REQ-008 sel_valid  input  1  a square is currently selected.
REQ-009 sel_sq  input  6  selected square index, row*8+col.
REQ-010 board_rd_addr  output  6  registered square index to the board RAM read port.
REQ-011 board_rd_data  input  4  piece code; valid exactly one cycle after board_rd_addr (synchronous RAM).
REQ-012 out_valid  output  1  pixel-valid delayed by 3 cycles.
REQ-013 in_board  output  1  pixel lies inside the 480x480 board area.
REQ-014 light_square  output  1  square colour; 1 = light.
REQ-015 highlight  output  1  pixel belongs to the selected square.
REQ-016 draw_piece  output  1  square holds a legal non-empty piece code.
REQ-017 rom_addr  output  17  sprite ROM address for this pixel.

Function
REQ-018 Stage 1 (T+1) SHALL register pix_valid, in_board, row, col, pixel offsets px_x/px_y (0..59), and drive board_rd_addr = row*8+col.
REQ-019 in_board SHALL be 1 iff X_ORIGIN <= DrawX < X_ORIGIN+480 and Y_ORIGIN <= DrawY < Y_ORIGIN+480.
REQ-020 row/col and offsets SHALL come from eight threshold compares at multiples of SQUARE_DIM; no divider instantiated.
REQ-021 Outside the board, row, col, px_x and px_y SHALL be registered as 0.
REQ-022 Stage 2 (T+2) SHALL carry stage-1 fields forward and capture board_rd_data.
REQ-023 Stage 3 (T+3) SHALL register rom_addr = base(piece) + px_y*60 + px_x, base from the *_ROM constants per piece code.
REQ-024 Piece codes EMPTY, 0111, 1000 and 1111 SHALL give draw_piece=0 and rom_addr=0.
REQ-025 draw_piece SHALL be 0 when in_board=0, regardless of board_rd_data.
REQ-026 light_square SHALL be 1 iff (row+col) is even; 0 outside the board.
REQ-027 highlight SHALL equal sel_valid && in_board && sel_sq==row*8+col, sampled at stage 1.
REQ-028 Latency SHALL be exactly 3 cycles, throughput one pixel per cycle, with no stalls.
REQ-029 When pix_valid=0, out_valid SHALL be 0 at T+3; all other outputs are don't-care.

Reset
REQ-030 While Reset=1, all pipeline registers SHALL load 0: board_rd_addr=0, out_valid=0, in_board=0, light_square=0, highlight=0, draw_piece=0, rom_addr=0.
REQ-031 Reset asserted mid-stream SHALL discard all in-flight pixels.
REQ-032 The first output after Reset deasserts SHALL come from a pixel presented after the deassertion.

Structure
REQ-033 Piece codes, *_ROM offsets, SQUARE_DIM and SCREEN_* limits SHALL come from package CONSTANTS; no local copies.
REQ-034 The piece-code-to-base lookup SHALL be a function in CONSTANTS, shared with other sprite users.
REQ-035 A single sub-module sq_locate SHALL implement the threshold quotient/remainder and be instantiated once per axis.

Verification
REQ-036 DrawX=80, DrawY=0, board[0]=ROOK_BLACK -> T+3: rom_addr=21600, draw_piece=1, light_square=1, in_board=1.
REQ-037 DrawX=139, DrawY=59, board[0]=ROOK_BLACK -> rom_addr=25199; then DrawX=140, DrawY=60, board[9]=EMPTY -> draw_piece=0, rom_addr=0, light_square=1.
REQ-038 DrawX=559, DrawY=479, board[63]=KING_WHITE, sel_valid=1, sel_sq=63 -> rom_addr=43199, highlight=1, light_square=1.
REQ-039 DrawX=79, then 560, then DrawY=480 -> in_board=0, draw_piece=0 for each; board[0]=PAWN_WHITE at DrawX=80 -> draw_piece=1.
REQ-040 Continuous scan of DrawX 80..559 on one line -> 480 consecutive out_valid cycles, each address matching the reference model.
REQ-041 Reset pulsed for 1 cycle with 3 pixels in flight -> outputs all 0 for the next 3 cycles, then correct results for new pixels.
